systolic_array_os: RTL and testbench

SYSTOLIC_ARRAY_OS -- requirements
Module: systolic_array_os

---
 rtl/systolic_array_os_if.sv | 26 ++
 rtl/systolic_array_os.sv | 111 +++++++++++
 tb/tb_systolic_array_os.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_os_if.sv
// Handshake and data bundle between a matrix source/sink and the output-stationary systolic array.
interface systolic_array_os_if #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 3,
    parameter int ACC_W = 12
);
    logic                        start;
    logic                        in_valid;
    logic                        in_ready;
    logic [SIZE*WIDTH-1:0]       a_in;
    logic [SIZE*WIDTH-1:0]       b_in;
    logic [SIZE*SIZE*ACC_W-1:0]  c_out;
    logic                        c_valid;
    logic                        c_ready;
    logic                        busy;

    modport master (
        output start, in_valid, a_in, b_in, c_ready,
        input  in_ready, c_out, c_valid, busy
    );

    modport slave (
        input  start, in_valid, a_in, b_in, c_ready,
        output in_ready, c_out, c_valid, busy
    );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier fed with pre-skewed A/B wavefronts.
// Result valid 3*SIZE-1 cycles after start plus input stalls; result held in DONE until c_ready.
module systolic_array_os #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 3,
    parameter int ACC_W = 12
) (
    input logic                clock,
    input logic                nreset,
    systolic_array_os_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam int CNT_W = $clog2(2 * SIZE);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(2 * SIZE - 2);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(SIZE - 2);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               clear;
    logic               beat;
    logic               step;
    logic               in_ready;
    logic               c_valid;
    logic               busy;

    logic [WIDTH-1:0]   a_reg [SIZE][SIZE];
    logic [WIDTH-1:0]   b_reg [SIZE][SIZE];
    logic [ACC_W-1:0]   acc   [SIZE][SIZE];
    logic [SIZE*SIZE*ACC_W-1:0] c_flat;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start)                  state_nx = LOAD;
            LOAD:    if (beat && cnt == LAST_BEAT)   state_nx = DRAIN;
            DRAIN:   if (cnt == LAST_DRAIN)          state_nx = DONE;
            DONE:    if (bus.c_ready)                state_nx = IDLE;
            default:                                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        c_valid  = (state == DONE);
        busy     = (state != IDLE);
        clear    = (state == IDLE) && bus.start;
        beat     = (state == LOAD) && bus.in_valid;
        step     = beat || (state == DRAIN);
    end

    // One counter serves both phases: beats in LOAD, then drain steps after wrapping to zero.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)                 cnt <= '0;
        else if (clear)              cnt <= '0;
        else if (beat)               cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
        else if (state == DRAIN)     cnt <= cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            logic [WIDTH-1:0]   left;
            logic [WIDTH-1:0]   top;
            logic [2*WIDTH-1:0] prod;

            // Edge lanes inject zero while draining so trailing steps add nothing.
            if (j == 0) begin : g_left_edge
                assign left = (state == LOAD) ? bus.a_in[i*WIDTH +: WIDTH] : '0;
            end else begin : g_left_inner
                assign left = a_reg[i][j-1];
            end

            if (i == 0) begin : g_top_edge
                assign top = (state == LOAD) ? bus.b_in[j*WIDTH +: WIDTH] : '0;
            end else begin : g_top_inner
                assign top = b_reg[i-1][j];
            end

            assign prod = {{WIDTH{1'b0}}, left} * {{WIDTH{1'b0}}, top};

            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else if (clear) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else if (step) begin
                    a_reg[i][j] <= left;
                    b_reg[i][j] <= top;
                    acc[i][j]   <= acc[i][j] + ACC_W'(prod);
                end
            end

            assign c_flat[(i*SIZE+j)*ACC_W +: ACC_W] = acc[i][j];
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.c_valid  = c_valid;
    assign bus.busy     = busy;
    assign bus.c_out    = c_flat;
endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: two instances (ACC_W 12 and 9) driven identically, checked against a matrix-product model.
module tb_systolic_array_os;
    localparam int S  = 3;
    localparam int W  = 4;
    localparam int AW = 12;
    localparam int BW = 9;

    typedef int mat_t [S][S];

    logic clock;
    logic nreset;
    logic start;
    logic in_valid;
    logic c_ready;
    logic [S*W-1:0] a_in;
    logic [S*W-1:0] b_in;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ready_cnt = 0;
    mat_t exp_c;

    systolic_array_os_if #(.WIDTH(W), .SIZE(S), .ACC_W(AW)) if_a ();
    systolic_array_os_if #(.WIDTH(W), .SIZE(S), .ACC_W(BW)) if_b ();

    assign if_a.start    = start;
    assign if_a.in_valid = in_valid;
    assign if_a.a_in     = a_in;
    assign if_a.b_in     = b_in;
    assign if_a.c_ready  = c_ready;
    assign if_b.start    = start;
    assign if_b.in_valid = in_valid;
    assign if_b.a_in     = a_in;
    assign if_b.b_in     = b_in;
    assign if_b.c_ready  = c_ready;

    systolic_array_os #(.WIDTH(W), .SIZE(S), .ACC_W(AW)) dut_a (
        .clock  (clock),
        .nreset (nreset),
        .bus    (if_a)
    );

    systolic_array_os #(.WIDTH(W), .SIZE(S), .ACC_W(BW)) dut_b (
        .clock  (clock),
        .nreset (nreset),
        .bus    (if_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (if_a.in_ready) ready_cnt <= ready_cnt + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int elem_a(input int i, input int j);
        return int'(if_a.c_out[(i*S+j)*AW +: AW]);
    endfunction

    function automatic int elem_b(input int i, input int j);
        return int'(if_b.c_out[(i*S+j)*BW +: BW]);
    endfunction

    // Whenever a result is presented, both instances must hold the model product modulo their width.
    always @(negedge clock) begin
        if (nreset && if_a.c_valid) begin
            for (int i = 0; i < S; i++)
                for (int j = 0; j < S; j++) begin
                    chk($sformatf("c12[%0d][%0d]", i, j), elem_a(i, j), exp_c[i][j] % (1 << AW));
                    chk($sformatf("c9[%0d][%0d]", i, j),  elem_b(i, j), exp_c[i][j] % (1 << BW));
                end
        end
    end

    task automatic outputs_zero(input string tag);
        chk({tag, " busy"},     int'(if_a.busy),       0);
        chk({tag, " in_ready"}, int'(if_a.in_ready),   0);
        chk({tag, " c_valid"},  int'(if_a.c_valid),    0);
        chk({tag, " c_out12"},  int'(if_a.c_out != '0), 0);
        chk({tag, " c_out9"},   int'(if_b.c_out != '0), 0);
        chk({tag, " busy9"},    int'(if_b.busy),       0);
    endtask

    task automatic drive_beat(input mat_t a, input mat_t b, input int t);
        for (int k = 0; k < S; k++) begin
            a_in[k*W +: W] = (t - k >= 0 && t - k < S) ? W'(a[k][t-k]) : '0;
            b_in[k*W +: W] = (t - k >= 0 && t - k < S) ? W'(b[t-k][k]) : '0;
        end
    endtask

    // Called at posedge+1; start is driven in the current cycle.
    task automatic run(input string tag, input mat_t a, input mat_t b,
                       input int stall_at, input int stall_len, input int bp_len);
        int  t0;
        bit  got;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < S; k++) exp_c[i][j] += a[i][k] * b[k][j];
            end
        c_ready   = (bp_len == 0);
        ready_cnt = 0;
        start     = 1'b1;
        t0        = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        for (int t = 0; t < 2*S-1; t++) begin
            if (t == stall_at) begin
                in_valid = 1'b0;
                a_in = '1;
                b_in = '1;
                repeat (stall_len) begin @(posedge clock); #1; end
            end
            in_valid = 1'b1;
            drive_beat(a, b, t);
            @(posedge clock); #1;
        end
        // Junk with in_valid high must not disturb drain or the held result.
        a_in = '1;
        b_in = '1;
        got  = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (if_a.c_valid) got = 1'b1;
        end
        chk({tag, " c_valid seen"}, int'(got), 1);
        chk({tag, " latency"}, cyc - t0, 3*S - 1 + stall_len);
        chk({tag, " in_ready cycles"}, ready_cnt, 2*S - 1 + stall_len);
        if (bp_len > 0) begin
            for (int k = 0; k < bp_len; k++) begin
                start = (k % 2 == 1);
                @(posedge clock); #1;
                start = 1'b0;
                @(negedge clock);
                chk({tag, " held c_valid"}, int'(if_a.c_valid), 1);
            end
            start   = 1'b1;
            c_ready = 1'b1;
            @(posedge clock); #1;
            start   = 1'b0;
            c_ready = 1'b0;
            chk({tag, " idle busy"}, int'(if_a.busy), 0);
            chk({tag, " idle c_valid"}, int'(if_a.c_valid), 0);
            @(posedge clock); #1;
            chk({tag, " no restart"}, int'(if_a.busy), 0);
        end else begin
            @(posedge clock); #1;
            chk({tag, " idle busy"}, int'(if_a.busy), 0);
        end
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
    endtask

    initial begin
        mat_t a_id, eye, f15, a_bp, b_seq, ones, a_dg;
        a_id  = '{'{1,2,3}, '{7,6,5}, '{8,9,4}};
        eye   = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
        f15   = '{'{15,15,15}, '{15,15,15}, '{15,15,15}};
        a_bp  = '{'{2,0,1}, '{3,4,5}, '{0,1,6}};
        b_seq = '{'{1,2,3}, '{4,5,6}, '{7,8,9}};
        ones  = '{'{1,1,1}, '{1,1,1}, '{1,1,1}};
        a_dg  = '{'{1,0,0}, '{0,2,0}, '{0,0,3}};

        nreset = 1'b0; start = 1'b0; in_valid = 1'b0; c_ready = 1'b0;
        a_in = '1; b_in = '1;
        #12;
        outputs_zero("reset");
        @(posedge clock); #1;
        nreset = 1'b1;
        in_valid = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        chk("idle ignores in_valid", int'(if_a.c_out != '0), 0);
        in_valid = 1'b0;

        run("identity", a_id, eye, -1, 0, 0);
        chk("identity c[0][2]", elem_a(0, 2), 3);
        chk("identity c[1][0]", elem_a(1, 0), 7);
        chk("identity c[2][1]", elem_b(2, 1), 9);

        run("fullscale", f15, f15, -1, 0, 0);
        chk("fullscale 12b", elem_a(2, 2), 675);
        chk("fullscale 9b",  elem_b(1, 1), 163);

        run("stall", a_id, eye, 2, 2, 0);
        chk("stall c[1][1]", elem_a(1, 1), 6);

        run("backtoback", ones, b_seq, -1, 0, 0);
        chk("backtoback c[2][0]", elem_a(2, 0), 12);
        chk("backtoback c[0][2]", elem_a(0, 2), 18);

        run("backpressure", a_bp, b_seq, -1, 0, 4);
        chk("backpressure c[1][2]", elem_a(1, 2), 78);
        chk("backpressure c[2][0]", elem_a(2, 0), 46);

        // Abort a run after three accepted beats.
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            drive_beat(f15, f15, t);
            @(posedge clock); #1;
        end
        nreset = 1'b0;
        #1;
        outputs_zero("midload reset");
        in_valid = 1'b0;
        @(posedge clock); #1;
        nreset = 1'b1;
        @(posedge clock); #1;
        chk("post reset idle", int'(if_a.busy), 0);

        run("diag", a_dg, ones, -1, 0, 0);
        chk("diag c[0][1]", elem_a(0, 1), 1);
        chk("diag c[1][2]", elem_a(1, 2), 2);
        chk("diag c[2][0]", elem_a(2, 0), 3);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
